// File: rtl/vga_timing_engine.sv
// Parametrised VGA timing engine: divides clock to a pixel tick, scans
// horizontal/vertical counters, and realigns sync/blank with a pipelined
// pixel generator so colour, syncs and n_blank leave on the same tick.
module vga_timing_engine #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 1,
  parameter int CW       = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [3*CW-1:0] rgb_in,
  output logic [9:0]      pixel_x,
  output logic [9:0]      pixel_y,
  output logic            pix_ce,
  output logic            frame_start,
  output logic            running,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic            vgaclock,
  output logic            hsync,
  output logic            vsync,
  output logic            n_blank
);
  // state   | meaning
  // S_IDLE  | counters parked at 0,0, syncs inactive, waiting for enable on a tick
  // S_RUN   | scanning frames back to back
  // S_DRAIN | enable dropped; finishing the current frame before parking

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a 1024-wide total cannot alias to zero
  localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]   HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]   VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic          frame_end;
  logic [10:0]   x_ext, y_ext;
  logic          act, hs, vs;
  logic [2:0]    raw_tv, dly_tv;

  assign div_nxt   = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
  assign pix_ce    = (div_cnt == DIV_LAST);
  assign frame_end = (pixel_x == H_LAST) && (pixel_y == V_LAST);

  // Free-running pixel divider; vgaclock is registered from the next count so
  // it tracks div_cnt >= CLK_DIV/2 without a combinational output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      vgaclock <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      vgaclock <= (div_nxt >= DIV_HALF);
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the state-derived strobes.
  always_comb begin
    state_nxt   = state;
    running     = 1'b0;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (pix_ce && enable) state_nxt = S_RUN;
      end
      S_RUN: begin
        running     = 1'b1;
        frame_start = pix_ce && (pixel_x == 10'd0) && (pixel_y == 10'd0);
        if (!enable) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        running = 1'b1;
        if (enable)                   state_nxt = S_RUN;
        else if (pix_ce && frame_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scan counters; parked at 0,0 while idle, the drain wrap lands there too.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (state == S_IDLE) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pix_ce) begin
      if (pixel_x == H_LAST) begin
        pixel_x <= '0;
        pixel_y <= (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
      end else begin
        pixel_x <= pixel_x + 10'd1;
      end
    end
  end

  // Raw active/sync decode from the counters.
  always_comb begin
    x_ext  = {1'b0, pixel_x};
    y_ext  = {1'b0, pixel_y};
    act    = (state != S_IDLE) && (x_ext < H_ACT) && (y_ext < V_ACT);
    hs     = (state != S_IDLE) && (x_ext >= HS_BEG) && (x_ext < HS_END);
    vs     = (state != S_IDLE) && (y_ext >= VS_BEG) && (y_ext < VS_END);
    raw_tv = {act, hs, vs};
  end

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign dly_tv = raw_tv;
    end else begin : g_dly
      logic [2:0] stage [PIPE_LAT];
      // Delay line matching the pixel generator latency.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < PIPE_LAT; i++) stage[i] <= 3'b000;
        end else if (pix_ce) begin
          stage[0] <= raw_tv;
          for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
        end
      end
      assign dly_tv = stage[PIPE_LAT-1];
    end
  endgenerate

  // Pin register: colour gated by the delayed active flag, syncs polarised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      n_blank <= 1'b0;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
    end else if (pix_ce) begin
      {red, green, blue} <= dly_tv[2] ? rgb_in : '0;
      n_blank <= dly_tv[2];
      hsync   <= dly_tv[1] ? HS_POL : ~HS_POL;
      vsync   <= dly_tv[0] ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine: instance A uses reduced timing with a
// 3-tick pixel generator, instance B a 4-clock divider with positive syncs.
module tb_vga_timing_engine;
  logic clock = 1'b0;
  logic rst_n;
  logic en_a, en_b;
  logic [23:0] rgb_in_a, rgb_in_b;
  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
  logic pix_ce_a, frame_start_a, running_a, vgaclock_a, hsync_a, vsync_a, n_blank_a;
  logic pix_ce_b, frame_start_b, running_b, vgaclock_b, hsync_b, vsync_b, n_blank_b;
  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic [23:0] gen0, gen1, gen2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vga_timing_engine #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(3), .CW(8)
  ) dut_a (
    .clock(clock), .reset(rst_n), .enable(en_a), .rgb_in(rgb_in_a),
    .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .pix_ce(pix_ce_a),
    .frame_start(frame_start_a), .running(running_a),
    .red(red_a), .green(green_a), .blue(blue_a), .vgaclock(vgaclock_a),
    .hsync(hsync_a), .vsync(vsync_a), .n_blank(n_blank_a)
  );

  vga_timing_engine #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(1), .CW(8)
  ) dut_b (
    .clock(clock), .reset(rst_n), .enable(en_b), .rgb_in(rgb_in_b),
    .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .pix_ce(pix_ce_b),
    .frame_start(frame_start_b), .running(running_b),
    .red(red_b), .green(green_b), .blue(blue_b), .vgaclock(vgaclock_b),
    .hsync(hsync_b), .vsync(vsync_b), .n_blank(n_blank_b)
  );

  function automatic logic [23:0] pix_colour(input logic [9:0] x, input logic [9:0] y);
    return {x[7:0] + 8'h10, y[7:0] + 8'h20, 8'h5A};
  endfunction

  // Pixel generator for A: colour of the coordinates three ticks back.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gen0 <= '0; gen1 <= '0; gen2 <= '0;
    end else if (pix_ce_a) begin
      gen0 <= pix_colour(pixel_x_a, pixel_y_a);
      gen1 <= gen0;
      gen2 <= gen1;
    end
  end
  assign rgb_in_a = gen2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_fs(input bit sel_b, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (sel_b ? (pix_ce_b && frame_start_b) : (pix_ce_a && frame_start_a)) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL wait_frame_start: none within %0d clocks (dut %s)", budget, sel_b ? "b" : "a"); end
  endtask

  task automatic wait_pos_a(input int x, input int y, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (pix_ce_a && pixel_x_a == 10'(x) && pixel_y_a == 10'(y)) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL wait_pos: (%0d,%0d) not reached within %0d clocks", x, y, budget); end
  endtask

  task automatic test_reset();
    checks++; if (pixel_x_a !== 10'd0 || pixel_y_a !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", pixel_x_a, pixel_y_a); end
    checks++; if ({pix_ce_a, frame_start_a, running_a, vgaclock_a} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {pix_ce_a, frame_start_a, running_a, vgaclock_a}); end
    checks++; if ({red_a, green_a, blue_a, n_blank_a} !== 25'd0) begin errors++; $display("FAIL reset_colour: got %h/%b expected 0", {red_a, green_a, blue_a}, n_blank_a); end
    checks++; if ({hsync_a, vsync_a} !== 2'b11) begin errors++; $display("FAIL reset_sync_a: got %b expected 11", {hsync_a, vsync_a}); end
    checks++; if ({hsync_b, vsync_b} !== 2'b00) begin errors++; $display("FAIL reset_sync_b: got %b expected 00", {hsync_b, vsync_b}); end
  endtask

  task automatic test_idle();
    int ce_cnt = 0;
    int fs_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (pix_ce_a) ce_cnt++;
      if (frame_start_a) fs_cnt++;
    end
    checks++; if (ce_cnt !== 10) begin errors++; $display("FAIL idle_divider: got %0d ticks expected 10", ce_cnt); end
    checks++; if (fs_cnt !== 0 || running_a !== 1'b0) begin errors++; $display("FAIL idle_state: fs=%0d running=%b expected 0,0", fs_cnt, running_a); end
    checks++; if (pixel_x_a !== 10'd0 || pixel_y_a !== 10'd0 || hsync_a !== 1'b1 || n_blank_a !== 1'b0) begin errors++; $display("FAIL idle_outputs: x=%0d y=%0d hs=%b nb=%b expected 0,0,1,0", pixel_x_a, pixel_y_a, hsync_a, n_blank_a); end
  endtask

  task automatic test_start_a();
    bit got;
    en_a = 1'b1;
    wait_fs(1'b0, 100, got);
    checks++; if (pixel_x_a !== 10'd0 || pixel_y_a !== 10'd0 || running_a !== 1'b1) begin errors++; $display("FAIL start_a: x=%0d y=%0d running=%b expected 0,0,1", pixel_x_a, pixel_y_a, running_a); end
  endtask

  task automatic test_frame_a();
    bit got;
    int ticks = 0, nb_cnt = 0, hs_cnt = 0, vs_cnt = 0, blank_col = 0, xy_err = 0, vga_err = 0;
    int nb_rise = -1, hs_fall = -1;
    logic [9:0] ex = 10'd0, ey = 10'd0;
    logic prev_hs;
    logic [23:0] col_rise = '0, col9 = '0;
    wait_fs(1'b0, 1200, got);
    prev_hs = hsync_a;
    for (int c = 0; c < 2000; c++) begin
      if (vgaclock_a !== pix_ce_a) vga_err++;
      if (pix_ce_a) begin
        if (ticks > 0 && frame_start_a) break;
        if (pixel_x_a !== ex || pixel_y_a !== ey) xy_err++;
        if (n_blank_a) nb_cnt++;
        if (!hsync_a) hs_cnt++;
        if (!vsync_a) vs_cnt++;
        if (!n_blank_a && {red_a, green_a, blue_a} !== 24'd0) blank_col++;
        if (n_blank_a && nb_rise < 0) begin nb_rise = ticks; col_rise = {red_a, green_a, blue_a}; end
        if (ticks > 0 && prev_hs && !hsync_a && hs_fall < 0) hs_fall = ticks;
        if (ticks == 9) col9 = {red_a, green_a, blue_a};
        prev_hs = hsync_a;
        if (ex == 10'd23) begin ex = 10'd0; ey = (ey == 10'd11) ? 10'd0 : ey + 10'd1; end
        else ex = ex + 10'd1;
        ticks++;
      end
      @(negedge clock);
    end
    checks++; if (ticks !== 288) begin errors++; $display("FAIL frame_len_a: got %0d ticks expected 288", ticks); end
    checks++; if (xy_err !== 0) begin errors++; $display("FAIL counters_a: %0d coordinate errors expected 0", xy_err); end
    checks++; if (nb_cnt !== 128) begin errors++; $display("FAIL active_a: got %0d n_blank ticks expected 128", nb_cnt); end
    checks++; if (hs_cnt !== 48) begin errors++; $display("FAIL hsync_a: got %0d low ticks expected 48", hs_cnt); end
    checks++; if (vs_cnt !== 48) begin errors++; $display("FAIL vsync_a: got %0d low ticks expected 48", vs_cnt); end
    checks++; if (blank_col !== 0) begin errors++; $display("FAIL blank_colour_a: got %0d nonzero blank ticks expected 0", blank_col); end
    checks++; if (nb_rise !== 4) begin errors++; $display("FAIL nblank_latency_a: got %0d expected 4", nb_rise); end
    checks++; if (col_rise !== 24'h10205A) begin errors++; $display("FAIL colour_at_rise_a: got %h expected 10205a", col_rise); end
    checks++; if (col9 !== 24'h15205A) begin errors++; $display("FAIL colour_x5_a: got %h expected 15205a", col9); end
    checks++; if (hs_fall !== 22) begin errors++; $display("FAIL hsync_latency_a: got %0d expected 22", hs_fall); end
    checks++; if (vga_err !== 0) begin errors++; $display("FAIL vgaclock_a: %0d phase errors expected 0", vga_err); end
  endtask

  task automatic test_glitch_a();
    bit got;
    int ticks = 0, run_drop = 0;
    wait_fs(1'b0, 1200, got);
    for (int c = 0; c < 2000; c++) begin
      if (c == 100) en_a = 1'b0;
      if (c == 101) en_a = 1'b1;
      @(negedge clock);
      if (!running_a) run_drop++;
      if (pix_ce_a) begin
        ticks++;
        if (frame_start_a) break;
      end
    end
    checks++; if (ticks !== 288) begin errors++; $display("FAIL glitch_frame_len: got %0d ticks expected 288", ticks); end
    checks++; if (run_drop !== 0) begin errors++; $display("FAIL glitch_running: dropped %0d clocks expected 0", run_drop); end
  endtask

  task automatic test_drain_a();
    bit got;
    int ticks = 0, fs_cnt = 0;
    wait_pos_a(5, 3, 1200, got);
    en_a = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (!running_a) break;
      if (pix_ce_a) ticks++;
    end
    checks++; if (ticks !== 210) begin errors++; $display("FAIL drain_ticks: got %0d expected 210", ticks); end
    checks++; if (running_a !== 1'b0 || pixel_x_a !== 10'd0 || pixel_y_a !== 10'd0) begin errors++; $display("FAIL drain_park: running=%b x=%0d y=%0d expected 0,0,0", running_a, pixel_x_a, pixel_y_a); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (frame_start_a) fs_cnt++;
    end
    checks++; if ({hsync_a, vsync_a, n_blank_a} !== 3'b110 || {red_a, green_a, blue_a} !== 24'd0) begin errors++; $display("FAIL drain_pins: hs/vs/nb=%b colour=%h expected 110 and 0", {hsync_a, vsync_a, n_blank_a}, {red_a, green_a, blue_a}); end
    checks++; if (fs_cnt !== 0 || pixel_x_a !== 10'd0 || running_a !== 1'b0) begin errors++; $display("FAIL drain_idle: fs=%0d x=%0d running=%b expected 0,0,0", fs_cnt, pixel_x_a, running_a); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int ticks = 0;
    en_a = 1'b1;
    wait_fs(1'b0, 200, got);
    wait_pos_a(20, 10, 1200, got);
    checks++; if (vsync_a !== 1'b0) begin errors++; $display("FAIL pre_reset_vsync: got %b expected 0", vsync_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pixel_x_a !== 10'd0 || pixel_y_a !== 10'd0 || running_a !== 1'b0) begin errors++; $display("FAIL midreset_state: x=%0d y=%0d running=%b expected 0,0,0", pixel_x_a, pixel_y_a, running_a); end
    checks++; if ({pix_ce_a, frame_start_a, vgaclock_a, n_blank_a, hsync_a, vsync_a} !== 6'b000011) begin errors++; $display("FAIL midreset_pins: got %b expected 000011", {pix_ce_a, frame_start_a, vgaclock_a, n_blank_a, hsync_a, vsync_a}); end
    @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (pix_ce_a) begin
        ticks++;
        if (frame_start_a) break;
      end
    end
    checks++; if (ticks !== 2) begin errors++; $display("FAIL restart_latency: got %0d ticks expected 2", ticks); end
    checks++; if (pixel_x_a !== 10'd0 || pixel_y_a !== 10'd0 || frame_start_a !== 1'b1) begin errors++; $display("FAIL restart_xy: x=%0d y=%0d fs=%b expected 0,0,1", pixel_x_a, pixel_y_a, frame_start_a); end
    en_a = 1'b0;
  endtask

  task automatic test_small_b();
    bit got;
    int ticks = 0, nb_cnt = 0, hs_cnt = 0, vs_cnt = 0, col_err = 0, xy_err = 0, ce_err = 0, vga_err = 0;
    int hs_rise = -1, vs_rise = -1, ph = 3, max_x = 0;
    logic [9:0] ex = 10'd0, ey = 10'd0;
    logic prev_hs, prev_vs;
    en_b = 1'b1;
    wait_fs(1'b1, 100, got);
    wait_fs(1'b1, 1000, got);
    prev_hs = hsync_b;
    prev_vs = vsync_b;
    for (int c = 0; c < 2000; c++) begin
      if (pix_ce_b) begin
        if (ticks > 0 && frame_start_b) break;
        if (pixel_x_b !== ex || pixel_y_b !== ey) xy_err++;
        if (int'(pixel_x_b) > max_x) max_x = int'(pixel_x_b);
        if (n_blank_b) nb_cnt++;
        if (hsync_b) hs_cnt++;
        if (vsync_b) vs_cnt++;
        if ({red_b, green_b, blue_b} !== (n_blank_b ? 24'hABCDEF : 24'd0)) col_err++;
        if (ticks > 0 && !prev_hs && hsync_b && hs_rise < 0) hs_rise = ticks;
        if (ticks > 0 && !prev_vs && vsync_b && vs_rise < 0) vs_rise = ticks;
        prev_hs = hsync_b;
        prev_vs = vsync_b;
        if (ex == 10'd13) begin ex = 10'd0; ey = (ey == 10'd6) ? 10'd0 : ey + 10'd1; end
        else ex = ex + 10'd1;
        ticks++;
      end
      @(negedge clock);
      ph = (ph + 1) % 4;
      if (pix_ce_b !== (ph == 3)) ce_err++;
      if (vgaclock_b !== (ph >= 2)) vga_err++;
    end
    checks++; if (ticks !== 98) begin errors++; $display("FAIL frame_len_b: got %0d ticks expected 98", ticks); end
    checks++; if (xy_err !== 0 || max_x !== 13) begin errors++; $display("FAIL counters_b: errors=%0d max_x=%0d expected 0,13", xy_err, max_x); end
    checks++; if (ce_err !== 0) begin errors++; $display("FAIL pix_ce_period_b: %0d errors expected 0", ce_err); end
    checks++; if (vga_err !== 0) begin errors++; $display("FAIL vgaclock_b: %0d errors expected 0", vga_err); end
    checks++; if (nb_cnt !== 32) begin errors++; $display("FAIL active_b: got %0d expected 32", nb_cnt); end
    checks++; if (hs_cnt !== 14 || vs_cnt !== 14) begin errors++; $display("FAIL sync_counts_b: hs=%0d vs=%0d expected 14,14", hs_cnt, vs_cnt); end
    checks++; if (hs_rise !== 12 || vs_rise !== 72) begin errors++; $display("FAIL sync_latency_b: hs=%0d vs=%0d expected 12,72", hs_rise, vs_rise); end
    checks++; if (col_err !== 0) begin errors++; $display("FAIL colour_b: %0d errors expected 0", col_err); end
    en_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    rgb_in_b = 24'hABCDEF;
    repeat (3) @(negedge clock);
    test_reset();
    rst_n = 1'b1;
    test_idle();
    test_start_a();
    test_frame_a();
    test_glitch_a();
    test_drain_a();
    test_reset_mid();
    test_small_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
